// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage in front of a synchronous instruction memory.
// Owns the PC and issues at most one fetch per cycle. Reads in flight are tracked by a
// fixed-latency shift register, and returned words land in a small skid FIFO, so a
// downstream stall never drops an instruction. A redirect squashes everything in flight
// and everything buffered.
//
// Ports
//   clk                   clock
//   rst                   asynchronous reset, active low
//   mem_pc_output         fetch address to the memory
//   mem_valid_output      fetch issued this cycle
//   instruction_data      memory read data, READ_LATENCY cycles after its address
//   redirect_valid_input  taken branch/jump
//   redirect_pc_input     redirect target
//   stall_input           downstream cannot accept this cycle
//   instr_valid_output    instr_pc_output / instr_output hold a valid instruction
//   instr_pc_output       PC of the presented instruction
//   instr_output          presented instruction word
module fetch_stage #(
    parameter int                         OPERAND_WIDTH = 32,
    parameter int                         READ_LATENCY  = 2,
    parameter int                         FIFO_DEPTH    = READ_LATENCY + 1,
    parameter logic [OPERAND_WIDTH-1:0]   RESET_PC      = '0,
    parameter int                         PC_STEP       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [OPERAND_WIDTH-1:0] mem_pc_output,
    output logic                     mem_valid_output,
    input  logic [OPERAND_WIDTH-1:0] instruction_data,
    input  logic                     redirect_valid_input,
    input  logic [OPERAND_WIDTH-1:0] redirect_pc_input,
    input  logic                     stall_input,
    output logic                     instr_valid_output,
    output logic [OPERAND_WIDTH-1:0] instr_pc_output,
    output logic [OPERAND_WIDTH-1:0] instr_output
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = $clog2(READ_LATENCY + FIFO_DEPTH + 1);
    localparam int LAST = READ_LATENCY - 1;
    localparam logic [OPERAND_WIDTH-1:0] PC_INC = OPERAND_WIDTH'(PC_STEP);

    logic [OPERAND_WIDTH-1:0] pc_q, pc_d;
    logic [READ_LATENCY-1:0]  infl_vld_q, infl_vld_d;
    logic [OPERAND_WIDTH-1:0] infl_pc_q [READ_LATENCY];
    logic [OPERAND_WIDTH-1:0] infl_pc_d [READ_LATENCY];
    logic [OPERAND_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [OPERAND_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OW-1:0]            inflight_cnt, occupancy;
    logic                     pop, push, issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OW'(infl_vld_q[i]);
        end
    end

    assign instr_valid_output = (cnt_q != '0);
    assign pop  = instr_valid_output && !stall_input;
    // The returning word is always accepted; the credit check below keeps room for it.
    assign push = infl_vld_q[LAST] && !redirect_valid_input;
    // Credit: every outstanding read already owns a FIFO slot, and a slot freed by this
    // cycle's pop can be reused by the fetch issued now.
    assign occupancy = inflight_cnt + OW'(cnt_q) - OW'(pop);
    assign issue     = !redirect_valid_input && (occupancy < OW'(FIFO_DEPTH));

    // Gate with the reset so nothing appears issued while reset is held.
    assign mem_valid_output = issue && rst;
    assign mem_pc_output    = pc_q;
    assign instr_pc_output  = instr_valid_output ? fifo_pc_q[head_q]   : '0;
    assign instr_output     = instr_valid_output ? fifo_data_q[head_q] : '0;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_input) begin
            pc_d = redirect_pc_input;
        end else if (issue) begin
            pc_d = pc_q + PC_INC;
        end

        infl_vld_d[0] = issue;
        infl_pc_d[0]  = pc_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            infl_vld_d[i] = infl_vld_q[i-1] && !redirect_valid_input;
            infl_pc_d[i]  = infl_pc_q[i-1];
        end

        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (redirect_valid_input) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            infl_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) infl_pc_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            infl_vld_q <= infl_vld_d;
            for (int i = 0; i < READ_LATENCY; i++) infl_pc_q[i] <= infl_pc_d[i];
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[tail_q]   <= infl_pc_q[LAST];
            fifo_data_q[tail_q] <= instruction_data;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a two-stage registered memory
// model returning mem[a] = a + 0x100.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] mem_pc;
    logic        mem_valid;
    logic [31:0] idata;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        stall;
    logic        ivalid;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic [31:0] addr_q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    fetch_stage #(.OPERAND_WIDTH(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_pc_output        (mem_pc),
        .mem_valid_output     (mem_valid),
        .instruction_data     (idata),
        .redirect_valid_input (redir_v),
        .redirect_pc_input    (redir_pc),
        .stall_input          (stall),
        .instr_valid_output   (ivalid),
        .instr_pc_output      (ipc),
        .instr_output         (instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered address, registered data
    always @(posedge clk) begin
        addr_q <= mem_pc;
        idata  <= addr_q + 32'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic out(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, ivalid}, {31'b0, v});
        if (v) begin
            chk({tag, "_pc"}, ipc, pc);
            chk({tag, "_instr"}, instr, pc + 32'h100);
        end
    endtask

    task automatic step(input logic s, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        cyc++;
        stall    = s;
        redir_v  = rv;
        redir_pc = rp;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; redir_v = 1'b0; redir_pc = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ivalid", {31'b0, ivalid}, 32'd0);
        chk("rst_mvalid", {31'b0, mem_valid}, 32'd0);
        chk("rst_ipc", ipc, 32'd0);
        chk("rst_instr", instr, 32'd0);

        // 1: streaming from reset
        @(negedge clk); rst = 1'b1; cyc = 0; #1;
        chk("t1_mpc0", mem_pc, 32'd0);
        chk("t1_mv0", {31'b0, mem_valid}, 32'd1);
        chk("t1_iv0", {31'b0, ivalid}, 32'd0);
        step(0, 0, 0); chk("t1_mpc1", mem_pc, 32'd1);
        step(0, 0, 0); chk("t1_mpc2", mem_pc, 32'd2); chk("t1_iv2", {31'b0, ivalid}, 32'd0);
        step(0, 0, 0); out("t1_c3", 1, 32'd0);
        step(0, 0, 0); out("t1_c4", 1, 32'd1);

        // 2: stall cycles 5..10
        for (int k = 5; k <= 10; k++) begin
            step(1, 0, 0);
            chk("t2_stall_mv", {31'b0, mem_valid}, 32'd0);
            out("t2_hold", 1, 32'd2);
        end
        step(0, 0, 0);
        out("t2_c11", 1, 32'd2);
        chk("t2_c11_mv", {31'b0, mem_valid}, 32'd1);
        chk("t2_c11_mpc", mem_pc, 32'd5);
        for (int k = 12; k <= 17; k++) begin
            step(0, 0, 0);
            out("t2_resume", 1, 32'(k - 9));
            chk("t2_resume_mv", {31'b0, mem_valid}, 32'd1);
        end

        // 3: redirect with two fetches in flight, cycle 18
        step(0, 1, 32'h40);
        chk("t3_r_mv", {31'b0, mem_valid}, 32'd0);
        out("t3_r", 1, 32'd9);
        step(0, 0, 0); out("t3_r1", 0, 0);
        chk("t3_r1_mpc", mem_pc, 32'h40); chk("t3_r1_mv", {31'b0, mem_valid}, 32'd1);
        step(0, 0, 0); out("t3_r2", 0, 0); chk("t3_r2_mpc", mem_pc, 32'h41);
        step(0, 0, 0); out("t3_r3", 0, 0);
        step(0, 0, 0); out("t3_r4", 1, 32'h40);
        step(0, 0, 0); out("t3_r5", 1, 32'h41);

        // 4: redirect while stalled with a full FIFO
        step(1, 0, 0); out("t4_c24", 1, 32'h42); chk("t4_c24_mv", {31'b0, mem_valid}, 32'd0);
        step(1, 0, 0); out("t4_c25", 1, 32'h42);
        step(1, 0, 0); out("t4_full", 1, 32'h42);
        step(1, 1, 32'h80); out("t4_r", 1, 32'h42); chk("t4_r_mv", {31'b0, mem_valid}, 32'd0);
        step(1, 0, 0); out("t4_flush", 0, 0);
        chk("t4_r1_mv", {31'b0, mem_valid}, 32'd1); chk("t4_r1_mpc", mem_pc, 32'h80);
        step(1, 0, 0); out("t4_r2", 0, 0); chk("t4_r2_mpc", mem_pc, 32'h81);
        step(1, 0, 0); out("t4_r3", 0, 0); chk("t4_r3_mv", {31'b0, mem_valid}, 32'd1);
        step(1, 0, 0); out("t4_r4", 1, 32'h80); chk("t4_r4_mv", {31'b0, mem_valid}, 32'd0);
        step(1, 0, 0); out("t4_r5", 1, 32'h80);
        step(0, 0, 0); out("t4_rel", 1, 32'h80); chk("t4_rel_mpc", mem_pc, 32'h83);
        step(0, 0, 0); out("t4_s1", 1, 32'h81);
        step(0, 0, 0); out("t4_s2", 1, 32'h82);
        step(0, 0, 0); out("t4_s3", 1, 32'h83);
        step(0, 0, 0); out("t4_s4", 1, 32'h84);

        // 5: asynchronous reset pulse mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("t5_ivalid", {31'b0, ivalid}, 32'd0);
        chk("t5_mvalid", {31'b0, mem_valid}, 32'd0);
        chk("t5_ipc", ipc, 32'd0);
        chk("t5_instr", instr, 32'd0);
        chk("t5_mpc", mem_pc, 32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; cyc = 0; #1;
        chk("t5_c0_mpc", mem_pc, 32'd0); chk("t5_c0_mv", {31'b0, mem_valid}, 32'd1);
        step(0, 0, 0); out("t5_c1", 0, 0);
        step(0, 0, 0); out("t5_c2", 0, 0);
        step(0, 0, 0); out("t5_c3", 1, 32'd0);
        step(0, 0, 0); out("t5_c4", 1, 32'd1);

        // 6: redirect to all-ones, PC wraps
        step(0, 1, 32'hFFFF_FFFF); chk("t6_r_mv", {31'b0, mem_valid}, 32'd0);
        step(0, 0, 0); chk("t6_mpc_top", mem_pc, 32'hFFFF_FFFF); out("t6_r1", 0, 0);
        step(0, 0, 0); chk("t6_mpc_wrap", mem_pc, 32'd0); chk("t6_r2_mv", {31'b0, mem_valid}, 32'd1);
        step(0, 0, 0); out("t6_r3", 0, 0);
        step(0, 0, 0); out("t6_top", 1, 32'hFFFF_FFFF);
        step(0, 0, 0); out("t6_zero", 1, 32'd0);
        step(0, 0, 0); out("t6_one", 1, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
